// File: rtl/i2s_mic_rx.sv
// i2s_mic_rx: I2S master for four stereo mic lines; generates SCK/WS and captures
// the top OUT_W bits of each left/right slot, publishing one complete frame at a time.
module i2s_mic_rx #(
    parameter int CLK_DIV = 8,
    parameter int OUT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [3:0]         mic_da,
    output logic               mic_clk,
    output logic               mic_ws,
    output logic [4*OUT_W-1:0] smp_l,
    output logic [4*OUT_W-1:0] smp_r,
    output logic               smp_valid,
    output logic               busy
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    localparam logic [7:0] DIV_TC = 8'(CLK_DIV - 1);
    localparam logic [4:0] LAST_P = 5'(OUT_W);
    state_t             r_state;
    logic [7:0]         r_div;
    logic [5:0]         r_bit;
    logic               r_sck;
    logic               r_ws;
    logic               r_valid;
    logic [4*OUT_W-1:0] r_sh_l;
    logic [4*OUT_W-1:0] r_sh_r;
    logic [4*OUT_W-1:0] r_hold_l;
    logic [4*OUT_W-1:0] r_smp_l;
    logic [4*OUT_W-1:0] r_smp_r;
    logic               w_tc;
    logic               w_rise;
    logic               w_fall;
    logic               w_cap;
    logic               w_last;
    logic [4:0]         w_p;
    logic [5:0]         w_bit_nxt;
    logic [4*OUT_W-1:0] w_sh_l;
    logic [4*OUT_W-1:0] w_sh_r;
    assign w_tc      = r_state != IDLE && r_div == DIV_TC;
    assign w_rise    = w_tc && !r_sck;
    assign w_fall    = w_tc && r_sck;
    assign w_p       = r_bit[4:0];
    // p=0 is the I2S delay bit; anything past OUT_W is truncated away
    assign w_cap     = w_rise && w_p != 5'd0 && w_p <= LAST_P;
    assign w_last    = w_rise && w_p == LAST_P;
    assign w_bit_nxt = r_bit + 6'd1;
    for (genvar g = 0; g < 4; g++) begin : g_line
        assign w_sh_l[g*OUT_W +: OUT_W] = (r_sh_l[g*OUT_W +: OUT_W] << 1) | OUT_W'(mic_da[g]);
        assign w_sh_r[g*OUT_W +: OUT_W] = (r_sh_r[g*OUT_W +: OUT_W] << 1) | OUT_W'(mic_da[g]);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_div    <= '0;
            r_bit    <= '0;
            r_sck    <= 1'b0;
            r_ws     <= 1'b0;
            r_valid  <= 1'b0;
            r_sh_l   <= '0;
            r_sh_r   <= '0;
            r_hold_l <= '0;
            r_smp_l  <= '0;
            r_smp_r  <= '0;
        end else begin
            r_valid <= w_last && r_bit[5];
            if (r_state == IDLE) begin
                r_div    <= '0;
                r_bit    <= '0;
                r_sck    <= 1'b0;
                r_ws     <= 1'b0;
                r_sh_l   <= '0;
                r_sh_r   <= '0;
                r_hold_l <= '0;
                if (en) r_state <= RUN;
            end else begin
                r_div <= w_tc ? '0 : r_div + 8'd1;
                if (w_tc) r_sck <= !r_sck;
                if (w_fall) begin
                    r_bit <= w_bit_nxt;
                    r_ws  <= w_bit_nxt[5];
                end
                if (w_cap && !r_bit[5]) r_sh_l <= w_sh_l;
                if (w_cap && r_bit[5]) r_sh_r <= w_sh_r;
                if (w_last && !r_bit[5]) r_hold_l <= w_sh_l;
                // left and right of the same frame are published together
                if (w_last && r_bit[5]) begin
                    r_smp_l <= r_hold_l;
                    r_smp_r <= w_sh_r;
                end
                if (w_fall && r_bit == 6'd63 && r_state == DRAIN && !en) r_state <= IDLE;
                else if (r_state == RUN && !en) r_state <= DRAIN;
                else if (r_state == DRAIN && en) r_state <= RUN;
            end
        end
    end
    assign mic_clk   = r_sck;
    assign mic_ws    = r_ws;
    assign smp_l     = r_smp_l;
    assign smp_r     = r_smp_r;
    assign smp_valid = r_valid;
    assign busy      = r_state != IDLE;
endmodule

// File: tb/tb_i2s_mic_rx.sv
// tb_i2s_mic_rx: two i2s_mic_rx instances (default and CLK_DIV=1/OUT_W=24) driven by
// an I2S mic model and checked each cycle against a frame-timing model.
module tb_i2s_mic_rx;
    localparam int CD0 = 8, W0 = 16, CD1 = 1, W1 = 24;
    int cd [2] = '{CD0, CD1};
    int wd [2] = '{W0, W1};
    logic clk = 1'b0;
    logic rst [2];
    logic en [2];
    logic [3:0] da [2];
    logic [31:0] lw [2][4];
    logic [31:0] rw [2][4];
    logic mck0, mws0, vld0, bsy0, mck1, mws1, vld1, bsy1;
    logic [63:0] sl0, sr0;
    logic [95:0] sl1, sr1;
    int passed = 0, total = 0, cycle = 0;
    bit act [2];
    int n [2];
    logic [95:0] el [2];
    logic [95:0] er [2];
    int pos [2];
    logic pmck [2];
    always #5 clk = ~clk;
    i2s_mic_rx #(.CLK_DIV(CD0), .OUT_W(W0)) u0 (
        .clk(clk), .rst(rst[0]), .en(en[0]), .mic_da(da[0]), .mic_clk(mck0), .mic_ws(mws0),
        .smp_l(sl0), .smp_r(sr0), .smp_valid(vld0), .busy(bsy0));
    i2s_mic_rx #(.CLK_DIV(CD1), .OUT_W(W1)) u1 (
        .clk(clk), .rst(rst[1]), .en(en[1]), .mic_da(da[1]), .mic_clk(mck1), .mic_ws(mws1),
        .smp_l(sl1), .smp_r(sr1), .smp_valid(vld1), .busy(bsy1));
    function automatic logic get(int d, int s);
        logic [3:0] v;
        v = d == 0 ? {mck0, mws0, vld0, bsy0} : {mck1, mws1, vld1, bsy1};
        return v[3-s];
    endfunction
    function automatic logic [95:0] gl(int d);
        return d == 0 ? {32'd0, sl0} : sl1;
    endfunction
    function automatic logic [95:0] gr(int d);
        return d == 0 ? {32'd0, sr0} : sr1;
    endfunction
    // expected sample word: top OUT_W bits of each line's slot word, line k at k*OUT_W
    function automatic logic [95:0] pack(int d, bit right);
        logic [95:0] res;
        logic [31:0] w;
        res = '0;
        for (int k = 0; k < 4; k++) begin
            w = right ? rw[d][k] : lw[d][k];
            for (int b = 0; b < wd[d]; b++) res[k*wd[d]+b] = w[32-wd[d]+b];
        end
        return res;
    endfunction
    function automatic logic [195:0] expv(int d);
        logic ck, ws, v;
        ck = act[d] && n[d] >= cd[d] && ((n[d] - cd[d]) / cd[d]) % 2 == 0;
        ws = act[d] && (n[d] / (2 * cd[d])) % 64 >= 32;
        v  = act[d] && n[d] % (128 * cd[d]) == cd[d] * (65 + 2 * wd[d]);
        return {ck, ws, v, logic'(act[d]), el[d], er[d]};
    endfunction
    // n = clk edges since the run began; first SCK rise at n=CLK_DIV, right-slot last bit captured at CLK_DIV*(65+2*OUT_W)
    always @(posedge clk) begin
        cycle++;
        for (int d = 0; d < 2; d++) begin
            if (rst[d]) begin
                act[d] = 1'b0;
                el[d]  = '0;
                er[d]  = '0;
            end else if (!act[d]) begin
                if (en[d]) begin
                    act[d] = 1'b1;
                    n[d]   = 0;
                end
            end else begin
                n[d]++;
                if (n[d] % (128 * cd[d]) == cd[d] * (65 + 2 * wd[d])) begin
                    el[d] = pack(d, 1'b0);
                    er[d] = pack(d, 1'b1);
                end
                if (n[d] % (128 * cd[d]) == 0 && !en[d]) act[d] = 1'b0;
            end
        end
    end
    // mic model: shifts slot bits MSB first one SCK after the slot starts
    always @(negedge clk) begin
        logic [31:0] wv;
        int p;
        for (int d = 0; d < 2; d++) begin
            if (!get(d, 3)) pos[d] = 0;
            else if (pmck[d] && !get(d, 0)) pos[d] = (pos[d] + 1) % 64;
            pmck[d] = get(d, 0);
            for (int k = 0; k < 4; k++) begin
                wv = pos[d] < 32 ? lw[d][k] : rw[d][k];
                p  = pos[d] % 32;
                da[d][k] = p == 0 ? ~wv[31] : wv[32-p];
            end
        end
    end
    always @(negedge clk) begin
        logic [195:0] a, e;
        for (int d = 0; d < 2; d++) begin
            a = {get(d, 0), get(d, 1), get(d, 2), get(d, 3), gl(d), gr(d)};
            e = expv(d);
            total++;
            if (a === e) passed++;
            else $display("FAIL cycle %0d dut%0d outputs got %h want %h", cycle, d, a, e);
        end
    end
    task automatic chk(string nm, logic [95:0] a, logic [95:0] e);
        total++;
        if (a === e) passed++;
        else $display("FAIL %s: got %h want %h", nm, a, e);
    endtask
    task automatic chki(string nm, int a, int e);
        total++;
        if (a == e) passed++;
        else $display("FAIL %s: got %0d want %0d", nm, a, e);
    endtask
    task automatic wu(int d, int s, logic val, int budget, output int c);
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (get(d, s) !== val && c < budget);
        if (get(d, s) !== val) begin
            total++;
            $display("FAIL timeout dut%0d sig%0d waiting for %0b", d, s, val);
        end
    endtask
    initial begin
        int c, a, b, t1, cnt;
        logic pv;
        logic [95:0] tmp;
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 4; k++) begin
                lw[d][k] = '0;
                rw[d][k] = '0;
            end
            da[d]  = '0;
            rst[d] = 1'b1;
            en[d]  = 1'b0;
        end
        repeat (2) @(negedge clk);
        chk("reset_smp", gl(0) | gr(0), '0);
        chk("reset_ctl", 96'({get(0, 0), get(0, 1), get(0, 2), get(0, 3)}), '0);
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        lw[0][1] = 32'hA5C3_F0F0;
        rw[0][1] = 32'h1234_8001;
        lw[0][3] = 32'h8000_7FFF;
        rw[0][3] = 32'h7FFF_FFFF;
        chk("model_pin_l", pack(0, 1'b0), 96'h8000_0000_A5C3_0000);
        chk("model_pin_r", pack(0, 1'b1), 96'h7FFF_0000_1234_0000);
        @(negedge clk);
        en[0] = 1'b1;
        wu(0, 0, 1'b1, 100, c);
        wu(0, 0, 1'b0, 100, a);
        wu(0, 0, 1'b1, 100, b);
        chki("sck_high", a, 8);
        chki("sck_period", a + b, 16);
        wu(0, 1, 1'b1, 2000, c);
        wu(0, 1, 1'b0, 2000, a);
        wu(0, 1, 1'b1, 2000, b);
        chki("ws_high", a, 512);
        chki("ws_period", a + b, 1024);
        chk("busy_run", 96'(get(0, 3)), 96'd1);
        wu(0, 2, 1'b1, 2000, c);
        chk("pat_l", gl(0), 96'h8000_0000_A5C3_0000);
        chk("pat_r", gr(0), 96'h7FFF_0000_1234_0000);
        wu(0, 2, 1'b0, 10, a);
        wu(0, 2, 1'b1, 2000, b);
        chki("valid_width", a, 1);
        chki("valid_period", a + b, 1024);
        wu(0, 1, 1'b0, 2000, c);
        repeat (10 * 16 + 4) @(negedge clk);
        en[0] = 1'b0;
        wu(0, 2, 1'b1, 1100, c);
        wu(0, 3, 1'b0, 1100, c);
        chki("drain_tail", c, 248);
        chk("drain_ctl", 96'({get(0, 0), get(0, 1), get(0, 2), get(0, 3)}), '0);
        chk("drain_keep_l", gl(0), 96'h8000_0000_A5C3_0000);
        chk("drain_keep_r", gr(0), 96'h7FFF_0000_1234_0000);
        cnt = 0;
        repeat (1100) begin
            @(negedge clk);
            if (get(0, 2)) cnt++;
        end
        chki("idle_no_valid", cnt, 0);
        lw[0][0] = 32'hDEAD_BEEF;
        rw[0][2] = 32'hC0DE_1111;
        lw[0][3] = 32'h0001_0000;
        rw[0][1] = 32'h0000_0000;
        en[0] = 1'b1;
        wu(0, 1, 1'b1, 2000, c);
        wu(0, 1, 1'b0, 2000, c);
        repeat (40 * 16 + 4) @(negedge clk);
        rst[0] = 1'b1;
        @(negedge clk);
        chk("rst_smp", gl(0) | gr(0), '0);
        chk("rst_ctl", 96'({get(0, 0), get(0, 1), get(0, 2), get(0, 3)}), '0);
        rst[0] = 1'b0;
        wu(0, 2, 1'b1, 1100, c);
        chki("restart_lat", c, 777);
        chk("restart_l", gl(0), 96'h0001_0000_A5C3_DEAD);
        chk("restart_r", gr(0), 96'h7FFF_C0DE_0000_0000);
        wu(0, 2, 1'b1, 1100, c);
        t1 = cycle;
        repeat (100) @(negedge clk);
        en[0] = 1'b0;
        repeat (5) @(negedge clk);
        en[0] = 1'b1;
        wu(0, 2, 1'b1, 1100, c);
        chki("reen_period", cycle - t1, 1024);
        for (int k = 0; k < 4; k++) begin
            lw[1][k] = $urandom;
            rw[1][k] = $urandom;
        end
        en[1] = 1'b1;
        wu(1, 2, 1'b1, 200, c);
        chki("cd1_first", c, 114);
        t1 = cycle;
        cnt = 0;
        pv = get(1, 0);
        repeat (8) begin
            @(negedge clk);
            if (get(1, 0) != pv) cnt++;
            pv = get(1, 0);
        end
        chki("cd1_toggle", cnt, 8);
        wu(1, 2, 1'b1, 200, c);
        chki("cd1_frame", cycle - t1, 128);
        for (int i = 0; i < 3; i++) begin
            tmp = gl(1);
            chk("cd1_l0", 96'(tmp[23:0]), 96'(lw[1][0][31:8]));
            tmp = gr(1);
            chk("cd1_r3", 96'(tmp[95:72]), 96'(rw[1][3][31:8]));
            for (int k = 0; k < 4; k++) begin
                lw[1][k] = $urandom;
                rw[1][k] = $urandom;
            end
            wu(1, 2, 1'b1, 200, c);
            chki("cd1_cadence", c, 128);
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
